tb_run_sequencer: RTL
=====================

// Module: tb_run_sequencer
// PURPOSE
// Synthesizable run controller placed between the simulation top and the testharness. It replaces the
// free-running reset, fetch-enable, timeout and exit-check processes with one FSM.
// It holds the harness in reset, then requests a firmware load and releases fetch enable.
// It counts run cycles, stops on exit or on the cycle budget, and latches a sticky result.
// PARAMETERS
// RESET_WAIT_CYCLES  4   cycles harness_rst_no is held low after start (>=1)
// CNT_W              32  width of cycle counter and max_cycles_i
// PORTS
// clk_i           in   1      clock
// rst_i           in   1      asynchronous reset, active-high
// start_i         in   1      1-cycle pulse: begin a run (honoured in IDLE and DONE only)
// max_cycles_i    in   CNT_W  run-cycle budget, sampled at start; 0 = unlimited
// load_done_i     in   1      firmware load complete (level, sampled in LOAD)
// exit_valid_i    in   1      harness exit strobe
// exit_value_i    in   32     harness exit code, valid with exit_valid_i
// harness_rst_no  out  1      active-low reset to testharness
// load_req_o      out  1      request firmware load (high throughout LOAD)
// fetch_enable_o  out  1      core fetch enable (high only in RUN)
// busy_o          out  1      FSM not in IDLE/DONE
// done_o          out  1      run finished (sticky until start_i or rst_i)
// pass_o          out  1      done with exit_value==0
// timeout_o       out  1      done due to cycle budget
// result_o        out  32     latched exit_value_i (0 on timeout)
// cycle_cnt_o     out  CNT_W  RUN cycles elapsed, saturating
// BEHAVIOUR
// - Reset (async, rst_i=1): state=IDLE, harness_rst_no=0, load_req_o=0, fetch_enable_o=0, busy_o=0,
//   done_o=0, pass_o=0, timeout_o=0, result_o=0, cycle_cnt_o=0, wait counter=0, budget reg=0.
//   Reset mid-run aborts immediately, with no result latched.
// - All outputs are registered. Every transition takes effect on the clock edge where its condition is seen.
// - IDLE: harness_rst_no=0. On start_i, latch max_cycles_i, clear wait counter and go to RSTW.
// - RSTW: harness_rst_no=0. The wait counter increments each cycle.
//   After exactly RESET_WAIT_CYCLES cycles in RSTW, go to LOAD.
// - LOAD: harness_rst_no=1, load_req_o=1, fetch_enable_o=0.
//   When load_done_i=1, go to RUN and clear cycle_cnt.
//   If load_done_i is already high on LOAD entry, LOAD lasts 1 cycle.
// - RUN: harness_rst_no=1, fetch_enable_o=1. cycle_cnt increments each RUN cycle and saturates at all-ones.
//   - exit_valid_i=1: result_o<=exit_value_i, pass_o<=(exit_value_i==0), timeout_o<=0, go to DONE.
//   - else if budget!=0 and cycle_cnt==budget-1: timeout_o<=1, pass_o<=0, result_o<=0, go to DONE.
//     This yields exactly `budget` RUN cycles.
//   - Simultaneous exit_valid_i and budget expiry: exit wins (pass/fail reported, timeout_o=0).
// - DONE: done_o=1, fetch_enable_o=0, harness_rst_no stays 1 (state preserved for inspection).
//   Outputs and cycle_cnt are frozen. exit_valid_i is ignored.
//   On start_i, clear done_o/pass_o/timeout_o/result_o and go to RSTW (new budget latched).
// - start_i in RSTW/LOAD/RUN is ignored. exit_valid_i outside RUN is ignored.
// - busy_o=1 in RSTW, LOAD and RUN.
// STRUCTURE
// - Package tb_run_pkg: typedef enum logic [2:0] {IDLE, RSTW, LOAD, RUN, DONE} tb_run_state_e;
//   localparam EXIT_SUCCESS = 32'h0.
// - Single module with no sub-modules.
//   The cycle counter (saturating, with load-clear) may be factored into tb_sat_counter #(CNT_W).
// TESTING
// 1. rst_i=1 for 3 cycles -> all outputs at their reset values. start_i ignored while rst_i=1.
// 2. start, max=0, load_done at LOAD+2, exit_valid with value 0 after 100 RUN cycles ->
//    harness_rst_no low for exactly 4 cycles, load_req_o high for 3 cycles, done_o=1, pass_o=1,
//    result_o=0, cycle_cnt_o=100.
// 3. start, max=50, no exit -> fetch_enable_o high for exactly 50 cycles; timeout_o=1, pass_o=0, cycle_cnt_o=49.
// 4. max=50 with exit_valid (value 7) on cycle_cnt==49 -> timeout_o=0, pass_o=0, result_o=7.
// 5. rst_i pulse during RUN at cycle 20 -> all outputs return to reset values asynchronously.
//    Then start again -> full RSTW/LOAD/RUN sequence repeats.
// 6. In DONE, start_i with max=10 -> flags clear next cycle, RSTW re-entered, 10-cycle timeout.
//    Additionally, start_i pulsed during RUN and exit_valid_i pulsed during LOAD have no effect.

Source files
------------

// File: rtl/tb_run_pkg.sv
// Shared types and constants for the simulation run sequencer.
package tb_run_pkg;

    typedef enum logic [2:0] {IDLE, RSTW, LOAD, RUN, DONE} tb_run_state_e;

    localparam logic [31:0] EXIT_SUCCESS = 32'h0;

endpackage

// File: rtl/tb_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module tb_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (en_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tb_run_sequencer.sv
// Run controller: holds the harness in reset, requests a firmware load, enables fetch,
// and stops on exit or cycle budget with a sticky, registered result.
module tb_run_sequencer
    import tb_run_pkg::*;
#(
    parameter int unsigned RESET_WAIT_CYCLES = 4,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] max_cycles_i,
    input  logic             load_done_i,
    input  logic             exit_valid_i,
    input  logic [31:0]      exit_value_i,
    output logic             harness_rst_no,
    output logic             load_req_o,
    output logic             fetch_enable_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [31:0]      result_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    localparam int unsigned      WAIT_W    = $clog2(RESET_WAIT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESET_WAIT_CYCLES - 1);

    tb_run_state_e     state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0]  budget_q;
    logic              budget_hit;
    logic              cnt_clr;
    logic              cnt_en;

    // Counter stops advancing on the terminating RUN cycle so it reports budget-1 on timeout.
    always_comb begin
        budget_hit = (budget_q != '0) && (cycle_cnt_o == budget_q - CNT_W'(1));
        cnt_clr    = (state_q == LOAD) && load_done_i;
        cnt_en     = (state_q == RUN) && !exit_valid_i && !budget_hit;
    end

    tb_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cycle_cnt_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            budget_q       <= '0;
            harness_rst_no <= 1'b0;
            load_req_o     <= 1'b0;
            fetch_enable_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            timeout_o      <= 1'b0;
            result_o       <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q        <= RSTW;
                        budget_q       <= max_cycles_i;
                        wait_cnt_q     <= '0;
                        harness_rst_no <= 1'b0;
                        busy_o         <= 1'b1;
                        done_o         <= 1'b0;
                        pass_o         <= 1'b0;
                        timeout_o      <= 1'b0;
                        result_o       <= '0;
                    end
                end
                RSTW: begin
                    wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q        <= LOAD;
                        harness_rst_no <= 1'b1;
                        load_req_o     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_done_i) begin
                        state_q        <= RUN;
                        load_req_o     <= 1'b0;
                        fetch_enable_o <= 1'b1;
                    end
                end
                RUN: begin
                    // Exit takes priority over a budget expiry in the same cycle.
                    if (exit_valid_i) begin
                        state_q        <= DONE;
                        fetch_enable_o <= 1'b0;
                        busy_o         <= 1'b0;
                        done_o         <= 1'b1;
                        result_o       <= exit_value_i;
                        pass_o         <= (exit_value_i == EXIT_SUCCESS);
                        timeout_o      <= 1'b0;
                    end else if (budget_hit) begin
                        state_q        <= DONE;
                        fetch_enable_o <= 1'b0;
                        busy_o         <= 1'b0;
                        done_o         <= 1'b1;
                        result_o       <= '0;
                        pass_o         <= 1'b0;
                        timeout_o      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
